sm_txt_crt_burst: RTL and testbench

- Parametrised text-mode CRT fetch sequencer in the VGA memory path.
- Per character group: issues TXT_BURST text-word requests (char/attr planes) and waits for the transfer to finish.
- Then issues FONT_BURST font-glyph requests, each driving one dummy FIFO read, with a selectable font plane (paged font).
- Tracks characters fetched per scanline; stops requesting once c_hde plus the panning margin is covered.

---
 rtl/sm_txt_pkg.sv | 17 +
 rtl/txt_burst_cnt.sv | 29 ++
 rtl/sm_txt_crt_burst.sv | 152 +++++++++++++++
 tb/tb_sm_txt_crt_burst.sv | 234 +++++++++++++++++++++++
 4 files changed

// File: rtl/sm_txt_pkg.sv
// rtl/sm_txt_pkg.sv - shared state encoding and defaults for the text-mode CRT fetch sequencer
package sm_txt_pkg;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        T_REQ  = 3'd1,
        T_WAIT = 3'd2,
        F_REQ  = 3'd3,
        F_WAIT = 3'd4
    } txt_state_e;

    localparam int DEF_PAN_EXTRA = 4;

    // Wide enough to hold a terminal value of 31 (bursts up to 32).
    localparam int BURST_CNT_W = 6;

endpackage

// File: rtl/txt_burst_cnt.sv
// rtl/txt_burst_cnt.sv - burst request counter with sync clear and terminal-count flag
module txt_burst_cnt #(
    parameter int W = 6
) (
    input  logic         mem_clk,
    input  logic         hreset_n,
    input  logic         clr,
    input  logic         inc,
    input  logic [W-1:0] last,
    output logic         tc
);

    logic [W-1:0] count;

    // Terminal count is the value just before wrap; the wrapping increment clears the counter.
    assign tc = (count == last);

    // Counter register: clear wins, otherwise wrap to zero on the terminal increment.
    always_ff @(posedge mem_clk or negedge hreset_n) begin
        if (!hreset_n) begin
            count <= '0;
        end else if (clr) begin
            count <= '0;
        end else if (inc) begin
            count <= tc ? '0 : count + W'(1);
        end
    end

endmodule

// File: rtl/sm_txt_crt_burst.sv
// rtl/sm_txt_crt_burst.sv - text-mode CRT fetch sequencer: text burst, then font burst, per character group
import sm_txt_pkg::*;

module sm_txt_crt_burst #(
    parameter int TXT_BURST  = 8,
    parameter int FONT_BURST = 8,
    parameter int HDE_W      = 8,
    parameter int PAN_EXTRA  = DEF_PAN_EXTRA,
    parameter int CNT_W      = HDE_W + 2
) (
    input  logic             mem_clk,
    input  logic             hreset_n,
    input  logic             sync_c_crt_line_end,
    input  logic             start_txt_sm,
    input  logic             crt_gnt,
    input  logic             text_mode,
    input  logic             svga_ack,
    input  logic             data_complete,
    input  logic             paged_font,
    input  logic [HDE_W-1:0] c_hde,
    output logic             txt_crt_svga_req,
    output logic             tx_cnt_inc,
    output logic             enrd_tx_addr,
    output logic             dum_ff_read,
    output logic             enrd_font_addr,
    output logic             extend_font_addr,
    output logic             font_plane_sel,
    output logic             busy,
    output logic             line_done
);

    localparam logic [BURST_CNT_W-1:0] TXT_LAST  = BURST_CNT_W'(TXT_BURST - 1);
    localparam logic [BURST_CNT_W-1:0] FONT_LAST = BURST_CNT_W'(FONT_BURST - 1);

    txt_state_e               state;
    txt_state_e               state_nx;
    logic [CNT_W-1:0]         char_count;
    logic [CNT_W-1:0]         hde_limit;
    logic [CNT_W:0]           char_sum;
    logic [BURST_CNT_W-1:0]   burst_last;
    logic                     burst_tc;
    logic                     cnt_inc;
    logic                     cnt_clr;
    logic                     grp_start;
    logic                     grp_done;

    // Quota covers the visible characters plus the panning margin.
    assign hde_limit = CNT_W'(c_hde) + CNT_W'(PAN_EXTRA);
    assign line_done = (char_count >= hde_limit);
    assign busy      = (state != IDLE);
    assign char_sum  = {1'b0, char_count} + (CNT_W+1)'(TXT_BURST);
    assign cnt_clr   = sync_c_crt_line_end | (state == IDLE);

    // One counter serves both phases; only the terminal value changes.
    txt_burst_cnt #(.W(BURST_CNT_W)) u_req_cnt (
        .mem_clk  (mem_clk),
        .hreset_n (hreset_n),
        .clr      (cnt_clr),
        .inc      (cnt_inc),
        .last     (burst_last),
        .tc       (burst_tc)
    );

    // State register.
    always_ff @(posedge mem_clk or negedge hreset_n) begin
        if (!hreset_n) begin
            state <= IDLE;
        end else begin
            state <= state_nx;
        end
    end

    // Next-state and strobe decode; line end overrides every transition.
    always_comb begin
        state_nx         = state;
        txt_crt_svga_req = 1'b0;
        tx_cnt_inc       = 1'b0;
        enrd_tx_addr     = 1'b0;
        dum_ff_read      = 1'b0;
        enrd_font_addr   = 1'b0;
        extend_font_addr = 1'b0;
        cnt_inc          = 1'b0;
        burst_last       = TXT_LAST;
        grp_start        = 1'b0;
        grp_done         = 1'b0;
        case (state)
            IDLE: begin
                if (crt_gnt && start_txt_sm && text_mode && !line_done) begin
                    state_nx  = T_REQ;
                    grp_start = 1'b1;
                end
            end
            T_REQ: begin
                txt_crt_svga_req = 1'b1;
                enrd_tx_addr     = 1'b1;
                if (svga_ack) begin
                    tx_cnt_inc = 1'b1;
                    cnt_inc    = 1'b1;
                    if (burst_tc) state_nx = T_WAIT;
                end
            end
            T_WAIT: begin
                if (data_complete) state_nx = F_REQ;
            end
            F_REQ: begin
                txt_crt_svga_req = 1'b1;
                extend_font_addr = 1'b1;
                burst_last       = FONT_LAST;
                if (svga_ack) begin
                    dum_ff_read    = 1'b1;
                    enrd_font_addr = 1'b1;
                    cnt_inc        = 1'b1;
                    if (burst_tc) state_nx = F_WAIT;
                end
            end
            F_WAIT: begin
                if (data_complete) begin
                    state_nx = IDLE;
                    grp_done = 1'b1;
                end
            end
            default: state_nx = IDLE;
        endcase
        if (sync_c_crt_line_end) begin
            state_nx  = IDLE;
            cnt_inc   = 1'b0;
            grp_start = 1'b0;
            grp_done  = 1'b0;
        end
    end

    // Per-line character count, saturating so a long line cannot wrap back below the quota.
    always_ff @(posedge mem_clk or negedge hreset_n) begin
        if (!hreset_n) begin
            char_count <= '0;
        end else if (sync_c_crt_line_end) begin
            char_count <= '0;
        end else if (grp_done) begin
            char_count <= char_sum[CNT_W] ? '1 : char_sum[CNT_W-1:0];
        end
    end

    // Font plane is frozen for the whole group at the moment the group starts.
    always_ff @(posedge mem_clk or negedge hreset_n) begin
        if (!hreset_n) begin
            font_plane_sel <= 1'b0;
        end else if (grp_start) begin
            font_plane_sel <= paged_font;
        end
    end

endmodule

// File: tb/tb_sm_txt_crt_burst.sv
// tb/tb_sm_txt_crt_burst.sv - scoreboard bench for the text-mode CRT fetch sequencer
module tb_sm_txt_crt_burst;

    localparam int T0 = 8;
    localparam int F0 = 8;
    localparam int T1 = 4;
    localparam int F1 = 2;
    localparam int PAN = 4;
    localparam int NLINES = 14;
    localparam int BUDGET = 20000;

    typedef struct packed {
        logic font;
        logic plane;
    } ev_t;

    logic       mem_clk = 1'b0;
    logic       hreset_n = 1'b0;
    logic       sync_c_crt_line_end = 1'b0;
    logic       start_txt_sm = 1'b0;
    logic       crt_gnt = 1'b0;
    logic       text_mode = 1'b0;
    logic       svga_ack = 1'b0;
    logic       data_complete = 1'b0;
    logic       paged_font = 1'b0;
    logic [7:0] c_hde = 8'd0;

    logic req [2];
    logic tx_inc [2];
    logic en_tx [2];
    logic dum [2];
    logic en_font [2];
    logic ext [2];
    logic plane [2];
    logic busy [2];
    logic done [2];

    ev_t q0[$];
    ev_t q1[$];

    int n_cmp = 0;
    int n_bad = 0;
    logic toggled = 1'b0;

    always #5 mem_clk = ~mem_clk;

    sm_txt_crt_burst #(.TXT_BURST(T0), .FONT_BURST(F0), .HDE_W(8), .PAN_EXTRA(PAN)) dut0 (
        .mem_clk(mem_clk), .hreset_n(hreset_n), .sync_c_crt_line_end(sync_c_crt_line_end),
        .start_txt_sm(start_txt_sm), .crt_gnt(crt_gnt), .text_mode(text_mode),
        .svga_ack(svga_ack), .data_complete(data_complete), .paged_font(paged_font), .c_hde(c_hde),
        .txt_crt_svga_req(req[0]), .tx_cnt_inc(tx_inc[0]), .enrd_tx_addr(en_tx[0]),
        .dum_ff_read(dum[0]), .enrd_font_addr(en_font[0]), .extend_font_addr(ext[0]),
        .font_plane_sel(plane[0]), .busy(busy[0]), .line_done(done[0])
    );

    sm_txt_crt_burst #(.TXT_BURST(T1), .FONT_BURST(F1), .HDE_W(8), .PAN_EXTRA(PAN)) dut1 (
        .mem_clk(mem_clk), .hreset_n(hreset_n), .sync_c_crt_line_end(sync_c_crt_line_end),
        .start_txt_sm(start_txt_sm), .crt_gnt(crt_gnt), .text_mode(text_mode),
        .svga_ack(svga_ack), .data_complete(data_complete), .paged_font(paged_font), .c_hde(c_hde),
        .txt_crt_svga_req(req[1]), .tx_cnt_inc(tx_inc[1]), .enrd_tx_addr(en_tx[1]),
        .dum_ff_read(dum[1]), .enrd_font_addr(en_font[1]), .extend_font_addr(ext[1]),
        .font_plane_sel(plane[1]), .busy(busy[1]), .line_done(done[1])
    );

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
        end
    endtask

    // Reference: a line needs ceil((c_hde+PAN)/T) groups; each group is T text
    // events then F font events; group 0 uses the starting plane, later groups the toggled one.
    task automatic push_line(input int d, input int hde, input logic p);
        int tb;
        int fb;
        int groups;
        ev_t e;
        tb = (d == 0) ? T0 : T1;
        fb = (d == 0) ? F0 : F1;
        groups = (hde + PAN + tb - 1) / tb;
        for (int g = 0; g < groups; g++) begin
            for (int i = 0; i < tb; i++) begin
                e = '{font: 1'b0, plane: 1'b0};
                if (d == 0) q0.push_back(e); else q1.push_back(e);
            end
            for (int i = 0; i < fb; i++) begin
                e = '{font: 1'b1, plane: (g == 0) ? p : ~p};
                if (d == 0) q0.push_back(e); else q1.push_back(e);
            end
        end
    endtask

    task automatic chk_ev(input int d, input logic font);
        ev_t e;
        logic have;
        logic [3:0] act;
        logic [3:0] exp;
        have = 1'b0;
        e = '0;
        if (d == 0) begin
            if (q0.size() > 0) begin have = 1'b1; e = q0.pop_front(); end
        end else begin
            if (q1.size() > 0) begin have = 1'b1; e = q1.pop_front(); end
        end
        if (!have) begin
            n_cmp++;
            n_bad++;
            $display("FAIL unexpected_event dut%0d actual=%0d required=none", d, font);
            return;
        end
        act = font ? {1'b1, plane[d], req[d], en_font[d] & ext[d]} : {1'b0, 1'b0, req[d], en_tx[d]};
        exp = {e.font, e.font ? e.plane : 1'b0, 2'b11};
        chk($sformatf("event_dut%0d", d), 32'(act), 32'(exp));
    endtask

    function automatic logic [7:0] outs(input int d);
        return {req[d], tx_inc[d], en_tx[d], dum[d], en_font[d], ext[d], busy[d], done[d]};
    endfunction

    task automatic toggle_check();
        if (!toggled && tx_inc[0]) begin
            paged_font = ~paged_font;
            toggled = 1'b1;
        end
    endtask

    task automatic line_end();
        @(posedge mem_clk); #1;
        sync_c_crt_line_end = 1'b1;
        start_txt_sm = 1'b0;
        @(posedge mem_clk); #1;
        sync_c_crt_line_end = 1'b0;
        @(negedge mem_clk);
        chk("after_line_end_dut0", 32'(outs(0)), 32'd0);
        chk("after_line_end_dut1", 32'(outs(1)), 32'd0);
        q0.delete();
        q1.delete();
    endtask

    // Random memory side: acks with occasional multi-cycle stalls, sporadic completions, grant mostly on.
    initial begin
        int stall;
        stall = 0;
        forever begin
            @(posedge mem_clk); #1;
            if (stall > 0) begin
                svga_ack = 1'b0;
                stall--;
            end else if ($urandom_range(0, 19) == 0) begin
                svga_ack = 1'b0;
                stall = 5;
            end else begin
                svga_ack = ($urandom_range(0, 9) < 7);
            end
            data_complete = ($urandom_range(0, 3) == 0);
            crt_gnt = ($urandom_range(0, 3) != 0);
        end
    end

    // Monitor: every strobe the DUTs present consumes one expected event.
    initial begin
        forever begin
            @(negedge mem_clk);
            if (hreset_n) begin
                for (int d = 0; d < 2; d++) begin
                    if (tx_inc[d]) chk_ev(d, 1'b0);
                    if (dum[d]) chk_ev(d, 1'b1);
                end
            end
        end
    end

    initial begin
        int hde;
        int cyc;
        int wait_n;
        logic p;
        logic abort;

        text_mode = 1'b1;
        repeat (2) @(negedge mem_clk);
        chk("reset_dut0", 32'({outs(0), plane[0]}), 32'd0);
        chk("reset_dut1", 32'({outs(1), plane[1]}), 32'd0);
        @(posedge mem_clk); #1;
        hreset_n = 1'b1;

        for (int ln = 0; ln < NLINES; ln++) begin
            case (ln)
                0: hde = 0;
                1: hde = 80;
                2: hde = 255;
                default: hde = $urandom_range(0, 60);
            endcase
            p = (ln == 0) ? 1'b1 : 1'($urandom_range(0, 1));
            abort = (ln >= 3) && ($urandom_range(0, 2) == 0);
            @(posedge mem_clk); #1;
            c_hde = 8'(hde);
            paged_font = p;
            toggled = 1'b0;
            push_line(0, hde, p);
            push_line(1, hde, p);
            start_txt_sm = 1'b1;

            if (abort) begin
                wait_n = $urandom_range(3, 60);
                repeat (wait_n) begin
                    @(negedge mem_clk);
                    toggle_check();
                end
            end else begin
                cyc = 0;
                while (!(done[0] && !busy[0] && done[1] && !busy[1]) && cyc < BUDGET) begin
                    @(negedge mem_clk);
                    toggle_check();
                    cyc++;
                end
                chk($sformatf("line%0d_in_budget", ln), 32'(cyc < BUDGET), 32'd1);
                repeat (5) begin
                    @(negedge mem_clk);
                    chk("no_req_after_done", 32'({req[0], req[1]}), 32'd0);
                end
                chk($sformatf("line%0d_events_left_dut0", ln), 32'(q0.size()), 32'd0);
                chk($sformatf("line%0d_events_left_dut1", ln), 32'(q1.size()), 32'd0);
            end
            line_end();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
